// File: rtl/sync_down_counter.sv
// Parameterised synchronous down counter: auto-reload or one-shot halt at zero, with a one-cycle underflow pulse.
// Optional Gray-coded count output is enabled by defining SYNC_DOWN_CNT_GRAY_OUT_EN.
module sync_down_counter #(
  parameter int unsigned      WIDTH      = 4,
  parameter logic [WIDTH-1:0] RELOAD_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             underflow,
  output logic             halted
`ifdef SYNC_DOWN_CNT_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q_next;
  logic             underflow_next;

  // Next-state values are resolved once here so the Gray output can be
  // registered from q_next and stay cycle-aligned with q.
  always_comb begin
    q_next         = q;
    state_next     = state;
    underflow_next = 1'b0;
    if (load) begin
      q_next     = load_val;
      state_next = RUN;
    end else if (state == RUN && en) begin
      if (q != '0) begin
        q_next = q - WIDTH'(1);
      end else begin
        underflow_next = 1'b1;
        if (auto_reload) begin
          q_next = RELOAD_VAL;
        end else begin
          q_next     = '0;
          state_next = HALT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= RELOAD_VAL;
      state     <= RUN;
      underflow <= 1'b0;
      halted    <= 1'b0;
`ifdef SYNC_DOWN_CNT_GRAY_OUT_EN
      q_gray    <= RELOAD_VAL ^ (RELOAD_VAL >> 1);
`endif
    end else begin
      q         <= q_next;
      state     <= state_next;
      underflow <= underflow_next;
      halted    <= (state_next == HALT);
`ifdef SYNC_DOWN_CNT_GRAY_OUT_EN
      q_gray    <= q_next ^ (q_next >> 1);
`endif
    end
  end

  assign zero = (q == '0);

endmodule
